ste_dma_snd_ctl: RTL

STE DMA sound frame controller: holds the frame start/end/counter registers and the play/loop control, and on each granted sound DMA slot fetches one word from RAM. It sits directly upstream of `gstshifter`'s sound FIFO. It consumes the shifter's `SREQ` and produces the `SLOAD_N` strobe plus the word address for the MCU address mux. It also signals frame end to the MFP (timer A / GPIP7).

---
 rtl/ste_dma_snd_ctl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ste_dma_snd_ctl.sv
// ste_dma_snd_ctl
// STE DMA sound frame controller. Holds the frame start/end/counter registers
// and the play/loop control, and fetches one RAM word per granted sound slot
// by pulsing SLOAD_N toward the shifter's sound FIFO.
//
// Ports:
//   clk32, resb        clock, synchronous active-low reset
//   CS, RW, A, DIN     CPU register access ($FF8900 window, low byte only)
//   DOUT               register read data, 0 unless CS & RW
//   SND_SLOT           one-cycle sound DMA grant from the MCU
//   SREQ               shifter FIFO not full
//   SLOAD_N, SADDR     load strobe and word address toward shifter / address mux
//   SACTIVE            frame playing (MFP GPIP7 / timer A)
//   FEND               one-cycle pulse at each frame end
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | not playing, waiting for play = 1
// S_ARM   | load counter/cur_end from the shadow start/end registers
// S_RUN   | frame active, waiting for a slot while the FIFO has room
// S_FETCH | SLOAD_N low for LOAD_CYCLES cycles, then advance the counter

module ste_dma_snd_ctl #(
  parameter int LOAD_CYCLES = 4
) (
  input  logic        clk32,
  input  logic        resb,
  input  logic        CS,
  input  logic        RW,
  input  logic [6:1]  A,
  input  logic [7:0]  DIN,
  output logic [7:0]  DOUT,
  input  logic        SND_SLOT,
  input  logic        SREQ,
  output logic        SLOAD_N,
  output logic [23:1] SADDR,
  output logic        SACTIVE,
  output logic        FEND
);

  localparam int CW = $clog2(LOAD_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_FETCH} state_t;

  state_t        state;
  logic          cs_q;
  logic          play;
  logic          loop_en;
  logic [7:0]    start_hi, start_mid;
  logic [7:1]    start_lo;
  logic [7:0]    end_hi, end_mid;
  logic [7:1]    end_lo;
  logic [23:1]   counter;
  logic [23:1]   cur_end;
  logic [CW-1:0] ld_cnt;

  logic          wr_stb;
  logic          wr_ctrl;
  logic          play_next;
  logic [23:1]   start_word;
  logic [23:1]   end_word;
  logic [23:1]   counter_inc;

  // A write is taken only on the first cycle of a CS write access.
  assign wr_stb      = CS & ~RW & ~cs_q;
  assign wr_ctrl     = wr_stb && (A == 6'h00);
  // IDLE reacts to the play write in the same cycle so ARM follows it directly.
  assign play_next   = wr_ctrl ? DIN[0] : play;
  assign start_word  = {start_hi, start_mid, start_lo};
  assign end_word    = {end_hi, end_mid, end_lo};
  assign counter_inc = counter + 23'd1;

  always_ff @(posedge clk32) begin
    if (!resb) begin
      state     <= S_IDLE;
      cs_q      <= 1'b0;
      play      <= 1'b0;
      loop_en   <= 1'b0;
      start_hi  <= '0;
      start_mid <= '0;
      start_lo  <= '0;
      end_hi    <= '0;
      end_mid   <= '0;
      end_lo    <= '0;
      counter   <= '0;
      cur_end   <= '0;
      ld_cnt    <= '0;
      SLOAD_N   <= 1'b1;
      SADDR     <= '0;
      SACTIVE   <= 1'b0;
      FEND      <= 1'b0;
    end else begin
      cs_q <= CS;
      FEND <= 1'b0;

      if (wr_stb) begin
        case (A)
          6'h01:   start_hi  <= DIN;
          6'h02:   start_mid <= DIN;
          6'h03:   start_lo  <= DIN[7:1];
          6'h07:   end_hi    <= DIN;
          6'h08:   end_mid   <= DIN;
          6'h09:   end_lo    <= DIN[7:1];
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          SACTIVE <= 1'b0;
          if (play_next) begin
            state   <= S_ARM;
            SACTIVE <= 1'b1;
          end
        end

        S_ARM: begin
          counter <= start_word;
          cur_end <= end_word;
          if (start_word == end_word) begin
            FEND <= 1'b1;
            // Looping an empty frame still honours a stop request.
            if (loop_en && play) begin
              state <= S_ARM;
            end else begin
              play    <= 1'b0;
              state   <= S_IDLE;
              SACTIVE <= 1'b0;
            end
          end else begin
            state <= S_RUN;
          end
        end

        S_RUN: begin
          if (!play) begin
            state   <= S_IDLE;
            SACTIVE <= 1'b0;
          end else if (SND_SLOT && SREQ) begin
            state   <= S_FETCH;
            SLOAD_N <= 1'b0;
            SADDR   <= counter;
            ld_cnt  <= CW'(LOAD_CYCLES - 1);
          end
        end

        S_FETCH: begin
          if (ld_cnt == '0) begin
            SLOAD_N <= 1'b1;
            counter <= counter_inc;
            // A stop during the strobe wins over a frame end: no FEND.
            if (!play) begin
              state   <= S_IDLE;
              SACTIVE <= 1'b0;
            end else if (counter_inc == cur_end) begin
              FEND <= 1'b1;
              if (loop_en) begin
                state <= S_ARM;
              end else begin
                play    <= 1'b0;
                state   <= S_IDLE;
                SACTIVE <= 1'b0;
              end
            end else begin
              state <= S_RUN;
            end
          end else begin
            ld_cnt <= ld_cnt - 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase

      // CPU control write lands last so it overrides an end-of-frame clear.
      if (wr_ctrl) begin
        play    <= DIN[0];
        loop_en <= DIN[1];
      end
    end
  end

  always_comb begin
    DOUT = 8'h00;
    if (CS && RW) begin
      case (A)
        6'h00:   DOUT = {6'b0, loop_en, play};
        6'h01:   DOUT = start_hi;
        6'h02:   DOUT = start_mid;
        6'h03:   DOUT = {start_lo, 1'b0};
        6'h04:   DOUT = counter[23:16];
        6'h05:   DOUT = counter[15:8];
        6'h06:   DOUT = {counter[7:1], 1'b0};
        6'h07:   DOUT = end_hi;
        6'h08:   DOUT = end_mid;
        6'h09:   DOUT = {end_lo, 1'b0};
        default: DOUT = 8'h00;
      endcase
    end
  end

endmodule
